// File: rtl/dec_pkg.sv
// Shared definitions for cmd_frame_decoder: header field offsets, FSM state encoding
// and the broadcast select value.
package dec_pkg;

  // Field offsets are relative to the first bit above the select field.
  localparam int HDR_RW_OFS    = 0;
  localparam int HDR_STIM_OFS  = 1;
  localparam int HDR_CLKP_OFS  = 2;
  localparam int HDR_RUN_OFS   = 3;
  localparam int HDR_START_OFS = 4;
  localparam int HDR_TRACE_OFS = 5;
  localparam int HDR_STEP_OFS  = 6;
  localparam int HDR_FPGA_OFS  = 7;

  localparam logic [31:0] SEL_BCAST = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_WDATA = 3'd2,
    ST_RDATA = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/dec_card_sel.sv
// Header select to one-hot card decoder. The decode is captured when a header is
// accepted; the invalid-select flag is combinational from the incoming select.
module dec_card_sel
  import dec_pkg::*;
#(
  parameter int SEL_W   = 4,
  parameter int N_CARDS = 14
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [SEL_W-1:0]   i_sel,
  input  logic               i_load,
  output logic [N_CARDS-1:0] o_card,
  output logic               o_invalid
);

  logic [N_CARDS-1:0] w_dec;
  logic [N_CARDS-1:0] r_card;
  logic               w_hit;
  logic               w_bcast;

  always_comb begin
    w_dec   = '0;
    w_hit   = 1'b0;
    w_bcast = (i_sel == SEL_BCAST[SEL_W-1:0]);
    for (int k = 1; k <= N_CARDS; k++) begin
      if (i_sel == SEL_W'(k)) begin
        w_dec[k-1] = 1'b1;
        w_hit      = 1'b1;
      end
    end
    if (w_bcast) w_dec = '1;
  end

  assign o_invalid = (i_sel != '0) && !w_bcast && !w_hit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_card <= '0;
    else if (i_load) r_card <= w_dec;
  end

  assign o_card = r_card;

endmodule

// File: rtl/cmd_frame_decoder.sv
// Command frame decoder: header, length, then write payload or read-back handshakes.
// Define DEC_TIMEOUT_EN to add an inter-word watchdog that aborts stalled frames.
module cmd_frame_decoder
  import dec_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int N_CARDS     = 14,
  parameter int SEL_W       = 4,
  parameter int FPGA_W      = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic               clk_ref,
  input  logic               rst_n,
  input  logic               dv_i,
  input  logic [DATA_W-1:0]  data_i,
  input  logic               data_send_i,
  output logic [N_CARDS-1:0] card_o,
  output logic [FPGA_W-1:0]  fpga_o,
  output logic               r_w_o,
  output logic               stim_o,
  output logic               clk_prog_o,
  output logic               run_verif_o,
  output logic               start_verif_o,
  output logic               trace_o,
  output logic               step_o,
  output logic               wait_data_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [DATA_W-1:0]  count_o
);

  localparam int CTL_W     = HDR_FPGA_OFS + FPGA_W;
  localparam int ABORT_POS = SEL_W + CTL_W;

  state_t             r_state, w_next;
  logic [CTL_W-1:0]   r_ctl;
  logic [DATA_W-1:0]  r_len, r_count, w_count_inc;
  logic [N_CARDS-1:0] r_card, w_card_dec;
  logic [FPGA_W-1:0]  r_fpga;
  logic r_rw, r_stim, r_clkp, r_run, r_start, r_trace, r_step;
  logic r_wait, r_busy, r_done, r_err;
  logic w_invalid, w_hdr_acc, w_len_acc, w_word, w_last, w_timeout;

  dec_card_sel #(.SEL_W(SEL_W), .N_CARDS(N_CARDS)) u_card_sel (
    .i_clk     (clk_ref),
    .i_rst_n   (rst_n),
    .i_sel     (data_i[SEL_W-1:0]),
    .i_load    (w_hdr_acc),
    .o_card    (w_card_dec),
    .o_invalid (w_invalid)
  );

  assign w_hdr_acc   = (r_state == ST_IDLE) && dv_i && !data_i[ABORT_POS];
  assign w_len_acc   = (r_state == ST_LEN) && dv_i;
  assign w_word      = ((r_state == ST_WDATA) && dv_i) || ((r_state == ST_RDATA) && data_send_i);
  assign w_count_inc = (r_count == '1) ? r_count : r_count + 1'b1;
  assign w_last      = w_word && (w_count_inc == r_len);

`ifdef DEC_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

  logic [WD_W-1:0] r_wdog;
  logic            w_active, w_progress;

  assign w_active   = (r_state == ST_LEN) || (r_state == ST_WDATA) || (r_state == ST_RDATA);
  assign w_progress = w_len_acc || w_word;
  // A word arriving on the expiry cycle counts as progress and wins.
  assign w_timeout  = w_active && !w_progress && (r_wdog == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n)                                  r_wdog <= '0;
    else if (!w_active || w_progress || w_timeout) r_wdog <= '0;
    else                                         r_wdog <= r_wdog + 1'b1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_hdr_acc) w_next = ST_LEN;
      ST_LEN: begin
        if (dv_i) begin
          if (data_i == '0)           w_next = ST_DONE;
          else if (r_ctl[HDR_RW_OFS]) w_next = ST_WDATA;
          else                        w_next = ST_RDATA;
        end
      end
      ST_WDATA, ST_RDATA: if (w_last) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    if (w_timeout) w_next = ST_IDLE;
  end

  // count_o keeps the final count visible alongside done_o and clears on leaving DONE.
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ctl   <= '0;
      r_len   <= '0;
      r_count <= '0;
      r_card  <= '0;
      r_fpga  <= '0;
      r_rw    <= 1'b0;
      r_stim  <= 1'b0;
      r_clkp  <= 1'b0;
      r_run   <= 1'b0;
      r_start <= 1'b0;
      r_trace <= 1'b0;
      r_step  <= 1'b0;
      r_wait  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != ST_IDLE);
      r_wait  <= (w_next == ST_WDATA);
      r_done  <= (w_next == ST_DONE);
      r_err   <= (w_hdr_acc && w_invalid) || w_timeout;
      if (w_hdr_acc) r_ctl <= data_i[SEL_W +: CTL_W];
      if (w_len_acc) r_len <= data_i;
      if (w_len_acc && (data_i != '0)) begin
        r_card  <= w_card_dec;
        r_fpga  <= r_ctl[HDR_FPGA_OFS +: FPGA_W];
        r_rw    <= r_ctl[HDR_RW_OFS];
        r_stim  <= r_ctl[HDR_STIM_OFS];
        r_clkp  <= r_ctl[HDR_CLKP_OFS];
        r_run   <= r_ctl[HDR_RUN_OFS];
        r_start <= r_ctl[HDR_START_OFS] & r_ctl[HDR_RW_OFS];
        r_trace <= r_ctl[HDR_TRACE_OFS];
        r_step  <= r_ctl[HDR_STEP_OFS] & r_ctl[HDR_RW_OFS];
      end else if ((w_next == ST_DONE) || w_timeout) begin
        r_card  <= '0;
        r_fpga  <= '0;
        r_rw    <= 1'b0;
        r_stim  <= 1'b0;
        r_clkp  <= 1'b0;
        r_run   <= 1'b0;
        r_start <= 1'b0;
        r_trace <= 1'b0;
        r_step  <= 1'b0;
      end
      if ((r_state == ST_DONE) || w_timeout) r_count <= '0;
      else if (w_word)                      r_count <= w_count_inc;
    end
  end

  assign card_o        = r_card;
  assign fpga_o        = r_fpga;
  assign r_w_o         = r_rw;
  assign stim_o        = r_stim;
  assign clk_prog_o    = r_clkp;
  assign run_verif_o   = r_run;
  assign start_verif_o = r_start;
  assign trace_o       = r_trace;
  assign step_o        = r_step;
  assign wait_data_o   = r_wait;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign err_o         = r_err;
  assign count_o       = r_count;

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Self-checking bench for cmd_frame_decoder: a 14-card and a 12-card instance share stimulus.
// Expected payload counts go through a scoreboard queue as words are driven.
module tb_cmd_frame_decoder;

  logic        clk_ref = 1'b0;
  logic        rst_n;
  logic        dv_i;
  logic [15:0] data_i;
  logic        data_send_i;

  logic [13:0] card_o;
  logic [3:0]  fpga_o;
  logic        r_w_o, stim_o, clk_prog_o, run_verif_o, start_verif_o, trace_o, step_o;
  logic        wait_data_o, busy_o, done_o, err_o;
  logic [15:0] count_o;

  logic [11:0] cardB;
  logic [3:0]  fpgaB;
  logic        rwB, stimB, clkProgB, runB, startB, traceB, stepB;
  logic        waitB, busyB, doneB, errB;
  logic [15:0] countB;

  int checks = 0;
  int passed = 0;
  int expQ[$];

  always #5 clk_ref = ~clk_ref;

  cmd_frame_decoder #(.DATA_W(16), .N_CARDS(14), .SEL_W(4), .FPGA_W(4), .TIMEOUT_CYC(8)) dut (
    .clk_ref(clk_ref), .rst_n(rst_n), .dv_i(dv_i), .data_i(data_i), .data_send_i(data_send_i),
    .card_o(card_o), .fpga_o(fpga_o), .r_w_o(r_w_o), .stim_o(stim_o), .clk_prog_o(clk_prog_o),
    .run_verif_o(run_verif_o), .start_verif_o(start_verif_o), .trace_o(trace_o), .step_o(step_o),
    .wait_data_o(wait_data_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .count_o(count_o)
  );

  cmd_frame_decoder #(.DATA_W(16), .N_CARDS(12), .SEL_W(4), .FPGA_W(4), .TIMEOUT_CYC(8)) dutB (
    .clk_ref(clk_ref), .rst_n(rst_n), .dv_i(dv_i), .data_i(data_i), .data_send_i(data_send_i),
    .card_o(cardB), .fpga_o(fpgaB), .r_w_o(rwB), .stim_o(stimB), .clk_prog_o(clkProgB),
    .run_verif_o(runB), .start_verif_o(startB), .trace_o(traceB), .step_o(stepB),
    .wait_data_o(waitB), .busy_o(busyB), .done_o(doneB), .err_o(errB), .count_o(countB)
  );

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk_ref);
    #1;
  endtask

  task automatic test_reset();
    $display("[TB] reset state");
    rst_n = 1'b0; dv_i = 1'b0; data_i = '0; data_send_i = 1'b0;
    #3;
    checks++; if (busy_o !== 1'b0) $display("[TB] FAIL rst_busy: got %b want 0", busy_o); else passed++;
    checks++; if (card_o !== 14'h0) $display("[TB] FAIL rst_card: got %h want 0", card_o); else passed++;
    checks++; if (count_o !== 16'h0) $display("[TB] FAIL rst_count: got %h want 0", count_o); else passed++;
    checks++; if ({done_o, err_o, wait_data_o, r_w_o} !== 4'b0) $display("[TB] FAIL rst_flags: got %b want 0000", {done_o, err_o, wait_data_o, r_w_o}); else passed++;
    checks++; if (busyB !== 1'b0) $display("[TB] FAIL rst_busyB: got %b want 0", busyB); else passed++;
    repeat (2) @(posedge clk_ref);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_write_frame();
    int exp;
    $display("[TB] write frame");
    dv_i = 1'b1; data_i = 16'h0031; tick();
    checks++; if (busy_o !== 1'b1) $display("[TB] FAIL wr_busy_len: got %b want 1", busy_o); else passed++;
    checks++; if (card_o !== 14'h0) $display("[TB] FAIL wr_card_len: got %h want 0", card_o); else passed++;
    data_i = 16'd3; tick();
    checks++; if (card_o !== 14'h0001) $display("[TB] FAIL wr_card: got %h want 0001", card_o); else passed++;
    checks++; if (stim_o !== 1'b1) $display("[TB] FAIL wr_stim: got %b want 1", stim_o); else passed++;
    checks++; if (r_w_o !== 1'b1) $display("[TB] FAIL wr_rw: got %b want 1", r_w_o); else passed++;
    checks++; if (wait_data_o !== 1'b1) $display("[TB] FAIL wr_wait: got %b want 1", wait_data_o); else passed++;
    checks++; if (count_o !== 16'd0) $display("[TB] FAIL wr_count0: got %0d want 0", count_o); else passed++;
    for (int k = 1; k <= 3; k++) begin
      dv_i = 1'b1; data_i = 16'($urandom); data_send_i = (k == 2);
      expQ.push_back(k);
      tick();
      exp = expQ.pop_front();
      checks++; if (count_o !== 16'(exp)) $display("[TB] FAIL wr_count: got %0d want %0d", count_o, exp); else passed++;
      checks++; if (done_o !== (k == 3)) $display("[TB] FAIL wr_done: got %b want %b", done_o, (k == 3)); else passed++;
      checks++; if (wait_data_o !== (k != 3)) $display("[TB] FAIL wr_wait_k: got %b want %b", wait_data_o, (k != 3)); else passed++;
    end
    checks++; if ({card_o, stim_o} !== 15'h0) $display("[TB] FAIL wr_done_clear: got %h want 0", {card_o, stim_o}); else passed++;
    dv_i = 1'b0; data_send_i = 1'b0; tick();
    checks++; if ({busy_o, done_o} !== 2'b00) $display("[TB] FAIL wr_idle: got %b want 00", {busy_o, done_o}); else passed++;
    checks++; if (count_o !== 16'd0) $display("[TB] FAIL wr_count_idle: got %0d want 0", count_o); else passed++;
  endtask

  task automatic test_read_frame();
    int exp;
    $display("[TB] read frame");
    dv_i = 1'b1; data_i = 16'h0182; tick();
    data_i = 16'd2; tick();
    checks++; if (card_o !== 14'h0002) $display("[TB] FAIL rd_card: got %h want 0002", card_o); else passed++;
    checks++; if (run_verif_o !== 1'b1) $display("[TB] FAIL rd_run: got %b want 1", run_verif_o); else passed++;
    checks++; if (start_verif_o !== 1'b0) $display("[TB] FAIL rd_start: got %b want 0", start_verif_o); else passed++;
    checks++; if ({r_w_o, wait_data_o} !== 2'b00) $display("[TB] FAIL rd_rw_wait: got %b want 00", {r_w_o, wait_data_o}); else passed++;
    data_i = 16'h1234; repeat (2) tick();
    checks++; if (count_o !== 16'd0) $display("[TB] FAIL rd_dv_ignored: got %0d want 0", count_o); else passed++;
    for (int k = 1; k <= 2; k++) begin
      data_send_i = 1'b1; dv_i = (k == 1);
      expQ.push_back(k);
      tick();
      exp = expQ.pop_front();
      checks++; if (count_o !== 16'(exp)) $display("[TB] FAIL rd_count: got %0d want %0d", count_o, exp); else passed++;
      checks++; if (done_o !== (k == 2)) $display("[TB] FAIL rd_done: got %b want %b", done_o, (k == 2)); else passed++;
      checks++; if (start_verif_o !== 1'b0) $display("[TB] FAIL rd_start_k: got %b want 0", start_verif_o); else passed++;
    end
    data_send_i = 1'b0; dv_i = 1'b0; tick();
    checks++; if (busy_o !== 1'b0) $display("[TB] FAIL rd_idle: got %b want 0", busy_o); else passed++;
  endtask

  task automatic test_zero_length();
    $display("[TB] zero length");
    dv_i = 1'b1; data_i = 16'h0013; tick();
    checks++; if (card_o !== 14'h0) $display("[TB] FAIL zl_card_len: got %h want 0", card_o); else passed++;
    data_i = 16'h0000; tick();
    checks++; if ({busy_o, done_o} !== 2'b11) $display("[TB] FAIL zl_done: got %b want 11", {busy_o, done_o}); else passed++;
    checks++; if ({card_o, wait_data_o} !== 15'h0) $display("[TB] FAIL zl_card_done: got %h want 0", {card_o, wait_data_o}); else passed++;
    dv_i = 1'b0; tick();
    checks++; if ({busy_o, done_o, card_o} !== 16'h0) $display("[TB] FAIL zl_idle: got %h want 0", {busy_o, done_o, card_o}); else passed++;
  endtask

  task automatic test_broadcast();
    $display("[TB] broadcast and invalid select");
    dv_i = 1'b1; data_i = 16'h000F; tick();
    checks++; if ({err_o, errB} !== 2'b00) $display("[TB] FAIL bc_err: got %b want 00", {err_o, errB}); else passed++;
    data_i = 16'd1; tick();
    checks++; if (card_o !== 14'h3FFF) $display("[TB] FAIL bc_card: got %h want 3fff", card_o); else passed++;
    checks++; if (cardB !== 12'hFFF) $display("[TB] FAIL bc_cardB: got %h want fff", cardB); else passed++;
    dv_i = 1'b0; data_send_i = 1'b1; tick();
    checks++; if ({done_o, doneB} !== 2'b11) $display("[TB] FAIL bc_done: got %b want 11", {done_o, doneB}); else passed++;
    data_send_i = 1'b0; tick();
    dv_i = 1'b1; data_i = 16'h000D; tick();
    checks++; if (errB !== 1'b1) $display("[TB] FAIL inv_errB: got %b want 1", errB); else passed++;
    checks++; if (err_o !== 1'b0) $display("[TB] FAIL inv_errA: got %b want 0", err_o); else passed++;
    data_i = 16'd1; tick();
    checks++; if (errB !== 1'b0) $display("[TB] FAIL inv_err_pulse: got %b want 0", errB); else passed++;
    checks++; if (cardB !== 12'h000) $display("[TB] FAIL inv_cardB: got %h want 000", cardB); else passed++;
    checks++; if (card_o !== 14'h1000) $display("[TB] FAIL sel13_card: got %h want 1000", card_o); else passed++;
    checks++; if (busyB !== 1'b1) $display("[TB] FAIL inv_runs: got %b want 1", busyB); else passed++;
    dv_i = 1'b0; data_send_i = 1'b1; tick();
    checks++; if ({done_o, doneB} !== 2'b11) $display("[TB] FAIL inv_done: got %b want 11", {done_o, doneB}); else passed++;
    data_send_i = 1'b0; tick();
  endtask

  task automatic test_abort_reset();
    int exp;
    $display("[TB] abort and mid-frame reset");
    dv_i = 1'b1; data_i = 16'h8001; tick();
    checks++; if ({busy_o, err_o} !== 2'b00) $display("[TB] FAIL abort_busy: got %b want 00", {busy_o, err_o}); else passed++;
    data_i = 16'h0035; tick();
    data_i = 16'd4; tick();
    checks++; if (card_o !== 14'h0010) $display("[TB] FAIL ar_card: got %h want 0010", card_o); else passed++;
    for (int k = 1; k <= 2; k++) begin
      data_i = 16'($urandom); expQ.push_back(k); tick();
      exp = expQ.pop_front();
      checks++; if (count_o !== 16'(exp)) $display("[TB] FAIL ar_count: got %0d want %0d", count_o, exp); else passed++;
    end
    dv_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({busy_o, wait_data_o, stim_o, r_w_o, done_o, err_o} !== 6'b0) $display("[TB] FAIL ar_flags: got %b want 000000", {busy_o, wait_data_o, stim_o, r_w_o, done_o, err_o}); else passed++;
    checks++; if ({card_o, fpga_o, count_o} !== 34'h0) $display("[TB] FAIL ar_data: got %h want 0", {card_o, fpga_o, count_o}); else passed++;
    tick();
    rst_n = 1'b1; dv_i = 1'b1; data_i = 16'h0031; tick();
    checks++; if (busy_o !== 1'b1) $display("[TB] FAIL ar_restart: got %b want 1", busy_o); else passed++;
    data_i = 16'd1; tick();
    checks++; if ({card_o, wait_data_o} !== 15'b000000000000011) $display("[TB] FAIL ar_card2: got %h want 0003", {card_o, wait_data_o}); else passed++;
    data_i = 16'hBEEF; expQ.push_back(1); tick();
    exp = expQ.pop_front();
    checks++; if (count_o !== 16'(exp) || done_o !== 1'b1) $display("[TB] FAIL ar_done: got count %0d done %b want %0d 1", count_o, done_o, exp); else passed++;
    dv_i = 1'b0; tick();
  endtask

  task automatic test_back_to_back();
    int exp;
    $display("[TB] back to back frames");
    dv_i = 1'b1; data_i = 16'h5654; tick();
    data_i = 16'd2; tick();
    checks++; if (card_o !== 14'h0008) $display("[TB] FAIL bb_card: got %h want 0008", card_o); else passed++;
    checks++; if (fpga_o !== 4'hA) $display("[TB] FAIL bb_fpga: got %h want a", fpga_o); else passed++;
    checks++; if ({r_w_o, stim_o, clk_prog_o, run_verif_o, start_verif_o, trace_o, step_o} !== 7'b1010011) $display("[TB] FAIL bb_flags: got %b want 1010011", {r_w_o, stim_o, clk_prog_o, run_verif_o, start_verif_o, trace_o, step_o}); else passed++;
    for (int k = 1; k <= 2; k++) begin
      data_i = 16'($urandom); expQ.push_back(k); tick();
      exp = expQ.pop_front();
      checks++; if (count_o !== 16'(exp)) $display("[TB] FAIL bb_count: got %0d want %0d", count_o, exp); else passed++;
    end
    checks++; if (done_o !== 1'b1) $display("[TB] FAIL bb_done: got %b want 1", done_o); else passed++;
    data_i = 16'h0031; tick();
    checks++; if (busy_o !== 1'b0) $display("[TB] FAIL bb_drop_in_done: got %b want 0", busy_o); else passed++;
    data_i = 16'h0642; tick();
    checks++; if (busy_o !== 1'b1) $display("[TB] FAIL bb_hdr2: got %b want 1", busy_o); else passed++;
    data_i = 16'd1; tick();
    checks++; if (card_o !== 14'h0002) $display("[TB] FAIL bb_card2: got %h want 0002", card_o); else passed++;
    checks++; if ({clk_prog_o, start_verif_o, trace_o, step_o} !== 4'b1010) $display("[TB] FAIL bb_rd_flags: got %b want 1010", {clk_prog_o, start_verif_o, trace_o, step_o}); else passed++;
    dv_i = 1'b0; data_send_i = 1'b1; expQ.push_back(1); tick();
    exp = expQ.pop_front();
    checks++; if (count_o !== 16'(exp) || done_o !== 1'b1) $display("[TB] FAIL bb_done2: got count %0d done %b want %0d 1", count_o, done_o, exp); else passed++;
    data_send_i = 1'b0; tick();
  endtask

  task automatic test_random_frames();
    int sel, rw, len, exp;
    logic [13:0] expCard;
    $display("[TB] random frames");
    for (int f = 0; f < 4; f++) begin
      sel = $urandom_range(1, 14); rw = $urandom_range(0, 1); len = $urandom_range(1, 5);
      expCard = 14'(1) << (sel - 1);
      dv_i = 1'b1; data_i = 16'(sel) | (16'(rw) << 4); tick();
      data_i = 16'(len); tick();
      checks++; if (card_o !== expCard) $display("[TB] FAIL rnd_card: got %h want %h", card_o, expCard); else passed++;
      for (int k = 1; k <= len; k++) begin
        dv_i = (rw == 1); data_send_i = (rw == 0); data_i = 16'($urandom);
        expQ.push_back(k); tick();
        exp = expQ.pop_front();
        checks++; if (count_o !== 16'(exp)) $display("[TB] FAIL rnd_count: got %0d want %0d", count_o, exp); else passed++;
        checks++; if (done_o !== (k == len)) $display("[TB] FAIL rnd_done: got %b want %b", done_o, (k == len)); else passed++;
      end
      dv_i = 1'b0; data_send_i = 1'b0; tick();
      checks++; if (busy_o !== 1'b0) $display("[TB] FAIL rnd_idle: got %b want 0", busy_o); else passed++;
    end
  endtask

`ifdef DEC_TIMEOUT_EN
  task automatic test_timeout();
    $display("[TB] watchdog");
    dv_i = 1'b1; data_i = 16'h0031; tick();
    data_i = 16'd2; tick();
    dv_i = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++; if (err_o !== (i == 8)) $display("[TB] FAIL to_err: cycle %0d got %b want %b", i, err_o, (i == 8)); else passed++;
      checks++; if (busy_o !== (i != 8)) $display("[TB] FAIL to_busy: cycle %0d got %b want %b", i, busy_o, (i != 8)); else passed++;
    end
    checks++; if ({done_o, card_o} !== 15'h0) $display("[TB] FAIL to_clear: got %h want 0", {done_o, card_o}); else passed++;
    dv_i = 1'b1; data_i = 16'h0031; tick();
    data_i = 16'd2; tick();
    dv_i = 1'b0; repeat (7) tick();
    dv_i = 1'b1; data_i = 16'h5555; tick();
    checks++; if ({busy_o, err_o, count_o} !== {2'b10, 16'd1}) $display("[TB] FAIL to_word_wins: got %h want 20001", {busy_o, err_o, count_o}); else passed++;
    dv_i = 1'b0; repeat (8) tick();
    checks++; if ({err_o, busy_o, done_o} !== 3'b100) $display("[TB] FAIL to_err2: got %b want 100", {err_o, busy_o, done_o}); else passed++;
    tick();
  endtask
`else
  task automatic test_stall();
    $display("[TB] stalled frame waits");
    dv_i = 1'b1; data_i = 16'h0031; tick();
    data_i = 16'd1; tick();
    dv_i = 1'b0; repeat (20) tick();
    checks++; if ({busy_o, err_o, wait_data_o} !== 3'b101) $display("[TB] FAIL stall_hold: got %b want 101", {busy_o, err_o, wait_data_o}); else passed++;
    dv_i = 1'b1; data_i = 16'h0F0F; tick();
    checks++; if ({done_o, count_o} !== {1'b1, 16'd1}) $display("[TB] FAIL stall_done: got %h want 10001", {done_o, count_o}); else passed++;
    dv_i = 1'b0; tick();
  endtask
`endif

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish, got hang want finish");
    $fatal(1, "[TB] hang");
  end

  initial begin
    test_reset();
    test_write_frame();
    test_read_frame();
    test_zero_length();
    test_broadcast();
    test_abort_reset();
    test_back_to_back();
    test_random_frames();
`ifdef DEC_TIMEOUT_EN
    test_timeout();
`else
    test_stall();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cmd_frame_decoder.md
CMD_FRAME_DECODER -- requirements
Module: cmd_frame_decoder

Interface
REQ-001 Parameter DATA_W, default 16: command/data word width; minimum 16.
REQ-002 Parameter N_CARDS, default 14: number of card-select outputs; range 1..(2**SEL_W)-2.
REQ-003 Parameter SEL_W, default 4: card-select field width in header.
REQ-004 Parameter FPGA_W, default 4: FPGA-select field width in header.
REQ-005 Parameter TIMEOUT_CYC, default 65535: idle cycles allowed between accepted frame words.
REQ-006 Ports, one per line:
- clk_ref  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- dv_i  in  1  data_i valid, one word per asserted cycle.
- data_i  in  DATA_W  header, length or write-payload word.
- data_send_i  in  1  one read-back word sent this cycle.
- card_o  out  N_CARDS  card select.
- fpga_o  out  FPGA_W  FPGA select.
- r_w_o  out  1  1 = write frame, 0 = read frame.
- stim_o, clk_prog_o, run_verif_o, start_verif_o, trace_o, step_o  out  1 each  header control flags.
- wait_data_o  out  1  write payload expected.
- busy_o  out  1  frame in progress.
- done_o  out  1  one-cycle frame-complete pulse.
- err_o  out  1  one-cycle pulse on invalid select or timeout.
- count_o  out  DATA_W  payload words transferred in current frame.

Function
REQ-010 Header layout: [SEL_W-1:0] select, then r_w, stim, clk_prog, run, start, trace, step, FPGA_W-bit fpga, then abort bit. Positions are defined only in dec_pkg.
REQ-011 FSM states: IDLE, LEN, WDATA, RDATA, DONE.
REQ-012 IDLE: dv_i with abort bit 0 latches header and moves to LEN. dv_i with abort bit 1 is discarded; state stays IDLE.
REQ-013 LEN: dv_i latches length N (unsigned, DATA_W bits). Next state is WDATA if r_w=1, RDATA if r_w=0, or DONE if N=0.
REQ-014 All outputs are registered. Control flags, fpga_o and card_o become valid in the cycle after the length word is accepted and hold until DONE.
REQ-015 WDATA: each dv_i increments count_o. wait_data_o=1 while in WDATA. Leave for DONE on the cycle the N-th word is accepted. data_send_i is ignored.
REQ-016 RDATA: each data_send_i increments count_o. Leave for DONE on the N-th pulse. dv_i is ignored. start_verif_o and step_o are forced to 0 during the read phase.
REQ-017 DONE lasts exactly one cycle: done_o=1, all flags, card_o and wait_data_o cleared, count_o reset to 0. Next state is IDLE.
REQ-018 A dv_i arriving in DONE is dropped.
REQ-019 card_o decode:
- select 0: all zeros.
- select k, 1..N_CARDS: bit k-1 set.
- select all-ones: all bits set (broadcast).
- any other select: all zeros, plus an err_o pulse in the cycle after the header. The frame still runs.
REQ-020 count_o is DATA_W bits and saturates at all-ones; it never wraps.
REQ-021 busy_o=1 in LEN, WDATA, RDATA and DONE.

Reset
REQ-030 rst_n low forces, asynchronously and in any state (including mid-frame): state=IDLE, all outputs 0, count_o=0, latched header=0, latched length=0.
REQ-031 Release of rst_n is honoured on the next clk_ref edge. A dv_i on that edge is treated as a header.

Configuration
REQ-040 Macro DEC_TIMEOUT_EN defined: a watchdog counter runs in LEN, WDATA and RDATA.
- It is cleared on every accepted word or data_send_i.
- On reaching TIMEOUT_CYC it pulses err_o, clears outputs as in DONE without done_o, and returns to IDLE.
- If a word and expiry coincide, the word wins and the counter clears.
REQ-041 Macro undefined: no watchdog logic; a stalled frame waits indefinitely.

Structure
REQ-050 Package dec_pkg holds: header bit-position constants, the FSM state enum, and the broadcast-select constant.
REQ-051 One sub-module, dec_card_sel: the registered select-to-card_o decoder, parameterised by SEL_W and N_CARDS, and producing the invalid-select flag.

Verification
REQ-060 Write frame: header 0x0031 (card 1, write, stim), length 3, three dv_i words. Required: card_o=0x0001, stim_o=1, wait_data_o=1, count_o 1..3; done_o one cycle after the 3rd word; busy_o=0 afterwards.
REQ-061 Read frame: header 0x0182 (card 2, run, start), length 2, two data_send_i pulses. Required: start_verif_o=0 during the read phase, count_o=2, done_o pulse; dv_i during RDATA is ignored.
REQ-062 Zero length: header 0x0013, length 0. Required: LEN goes to DONE, done_o pulses, card_o was never asserted.
REQ-063 Broadcast/invalid (N_CARDS=14): select 0xF gives card_o=0x3FFF. With N_CARDS=12, select 0xD gives card_o=0 and an err_o pulse.
REQ-064 Abort and reset: header 0x8001 in IDLE leaves busy_o=0. rst_n asserted after the 2nd of 4 write words gives all outputs 0 immediately; the next header starts cleanly.
REQ-065 DEC_TIMEOUT_EN, TIMEOUT_CYC=8: stall after the length word. Required: err_o at cycle 8, return to IDLE, no done_o. A word arriving exactly at cycle 8 is accepted.
